fft_pipe_sequencer: RTL and testbench

- Sequencer for the 32-point radix-2 single-delay-feedback FFT pipeline, i.e. the chain of per-stage blocks such as STAGE1.
- Generates the shared pipeline enable, per-stage butterfly/bypass selects and the input-zero (flush) control.
- Tracks pipeline fill, raises out_valid with a bit-reversed output index, and drains the last frame by injecting zeros when the source goes idle.

---
 rtl/fft_pipe_sequencer.sv | 162 ++++++++++++++++
 tb/tb_fft_pipe_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_pipe_sequencer.sv
// Sequencer for a radix-2 single-delay-feedback FFT pipeline.
// Produces the shared pipeline enable, per-stage butterfly selects, the
// flush (zero-inject) control, and a bit-reversed output index with valid.
//
// Handshake: a sample is taken on a rising edge where in_valid && in_ready.
// in_ready is low only while the last frame is being drained with zeros;
// in_valid may be held high across that window and is accepted once the
// sequencer returns to IDLE.
module fft_pipe_sequencer #(
  parameter int N        = 32,
  parameter int LOG2N    = 5,
  parameter int PIPE_LAT = 35,
  parameter int CW       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pipe_en,
  output logic             zero_in,
  output logic [LOG2N-1:0] sample_cnt,
  output logic [LOG2N-1:0] bf_sel,
  output logic             out_valid,
  output logic [LOG2N-1:0] out_idx,
  output logic             frame_done,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [LOG2N-1:0] r_sample_cnt;
  logic [LOG2N-1:0] r_out_cnt;
  logic [LOG2N-1:0] r_en_cnt;
  logic [CW-1:0]    r_fill;
  logic [CW-1:0]    r_pending;
  logic [CW-1:0]    w_pending_nxt;
  logic             r_frame_done;
  logic             w_in_ready;
  logic             w_pipe_en;
  logic             w_zero_in;
  logic             w_flush;
  logic             w_to_idle;
  logic             w_out_valid;
  logic             w_accept;
  logic [LOG2N-1:0] w_bf_sel;
  logic [LOG2N-1:0] w_out_idx;

  // Offset of stage s: cumulative feedback delay of earlier stages plus one
  // register per stage, reduced mod N.
  function automatic logic [LOG2N-1:0] stage_ofs(input int s);
    return LOG2N'(((N - (N >> s)) + s) % N);
  endfunction

  // Next state and control. A boundary idle cycle in RUN with results still
  // pending already behaves as the first flush cycle, so the drain starts
  // without losing an enabled cycle.
  always_comb begin
    w_next_state = r_state;
    w_in_ready   = 1'b1;
    w_pipe_en    = 1'b0;
    w_zero_in    = 1'b0;
    w_flush      = 1'b0;
    w_to_idle    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pipe_en = in_valid;
        if (in_valid) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (in_valid) begin
          w_pipe_en = 1'b1;
        end else if (r_sample_cnt == '0) begin
          if (r_pending != '0) w_flush = 1'b1;
          else                 w_to_idle = 1'b1;
        end
      end
      S_FLUSH: w_flush = 1'b1;
      default: w_to_idle = 1'b1;
    endcase
    if (w_flush) begin
      w_in_ready = 1'b0;
      w_pipe_en  = 1'b1;
      w_zero_in  = 1'b1;
    end
    w_out_valid = w_pipe_en && (r_fill == CW'(PIPE_LAT));
    w_accept    = in_valid && w_in_ready;
    w_pending_nxt = r_pending;
    if (w_accept && !w_out_valid)      w_pending_nxt = r_pending + CW'(1);
    else if (w_out_valid && !w_accept) w_pending_nxt = r_pending - CW'(1);
    if (w_flush) begin
      if (w_pending_nxt == '0) w_to_idle = 1'b1;
      else                     w_next_state = S_FLUSH;
    end
    if (w_to_idle) w_next_state = S_IDLE;
  end

  // Per-stage butterfly select and bit-reversed output bin.
  always_comb begin
    w_bf_sel  = '0;
    w_out_idx = '0;
    for (int s = 0; s < LOG2N; s++) begin
      logic [LOG2N-1:0] c;
      c = r_en_cnt - stage_ofs(s);
      w_bf_sel[s]  = c[LOG2N-1-s];
      w_out_idx[s] = r_out_cnt[LOG2N-1-s];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Fill and enabled-cycle counters; both restart when returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill   <= '0;
      r_en_cnt <= '0;
    end else if (w_to_idle) begin
      r_fill   <= '0;
      r_en_cnt <= '0;
    end else if (w_pipe_en) begin
      r_fill   <= (r_fill == CW'(PIPE_LAT)) ? r_fill : r_fill + CW'(1);
      r_en_cnt <= r_en_cnt + LOG2N'(1);
    end
  end

  // Sample, output and pending counters plus the end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
      r_out_cnt    <= '0;
      r_pending    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_accept)    r_sample_cnt <= r_sample_cnt + LOG2N'(1);
      if (w_out_valid) r_out_cnt    <= r_out_cnt + LOG2N'(1);
      r_pending    <= w_pending_nxt;
      r_frame_done <= w_out_valid && (r_out_cnt == LOG2N'(N - 1));
    end
  end

  assign in_ready   = w_in_ready;
  assign pipe_en    = w_pipe_en;
  assign zero_in    = w_zero_in;
  assign sample_cnt = r_sample_cnt;
  assign bf_sel     = w_bf_sel;
  assign out_valid  = w_out_valid;
  assign out_idx    = w_out_idx;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_fft_pipe_sequencer.sv
// Self-checking bench for fft_pipe_sequencer: cycle-exact window checks on
// the control outputs plus an expected-bin queue for the output order.
module tb_fft_pipe_sequencer;

  localparam int N  = 32;
  localparam int LW = 5;

  // Clock / reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready, pipe_en, zero_in, out_valid, frame_done, busy;
  logic [LW-1:0] sample_cnt, bf_sel, out_idx;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  fft_pipe_sequencer #(.N(N), .LOG2N(LW), .PIPE_LAT(35), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pipe_en(pipe_en), .zero_in(zero_in), .sample_cnt(sample_cnt),
    .bf_sel(bf_sel), .out_valid(out_valid), .out_idx(out_idx),
    .frame_done(frame_done), .busy(busy), .dbg_state(dbg_state)
  );

  // Scoreboard
  int            n_checks = 0;
  int            n_errors = 0;
  logic [LW-1:0] exp_q[$];
  int            stage_ofs[5] = '{0, 17, 26, 31, 34};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] bitrev(input int k);
    logic [LW-1:0] v, r;
    v = LW'(k);
    for (int i = 0; i < LW; i++) r[i] = v[LW-1-i];
    return r;
  endfunction

  function automatic logic [LW-1:0] exp_bf(input int e);
    logic [LW-1:0] r;
    for (int s = 0; s < LW; s++) begin
      int d;
      d = (e - stage_ofs[s] + 128) % N;
      r[s] = ((d >> (LW - 1 - s)) & 1) != 0;
    end
    return r;
  endfunction

  task automatic pop_check();
    if (out_valid) begin
      chk("sb_underflow", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("out_idx", out_idx, exp_q.pop_front());
    end
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_pipe_en"}, pipe_en, 0);
    chk({tag, "_zero_in"}, zero_in, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sample_cnt"}, sample_cnt, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_out_idx"}, out_idx, 0);
    chk({tag, "_bf_sel"}, bf_sel, exp_bf(0));
  endtask

  // Driver: n_frames contiguous frames with an optional stall window;
  // cycle 0 is the first cycle in_valid is offered. rst_cyc >= 0 aborts
  // the run by asserting reset in that cycle (reset is left asserted).
  task automatic run_frame(input int stall_lo, input int stall_hi,
                           input int n_frames, input int rst_cyc);
    int   nstall, last_in, out_lo, out_hi, acc, e;
    logic v, fl, en;
    nstall  = (stall_lo >= 0) ? (stall_hi - stall_lo + 1) : 0;
    last_in = N * n_frames + nstall;
    out_lo  = 35 + nstall;
    out_hi  = out_lo + N * n_frames - 1;
    acc = 0;
    e   = 0;
    for (int c = 0; c <= out_hi + 2; c++) begin
      v  = (c < last_in) && !(c >= stall_lo && c <= stall_hi);
      fl = (c >= last_in) && (c <= out_hi);
      en = v || fl;
      if (c == rst_cyc) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_idle_outs("async_rst");
        exp_q.delete();
        return;
      end
      in_valid = v;
      @(negedge clk);
      chk("in_ready", in_ready, !fl);
      chk("pipe_en", pipe_en, en);
      chk("zero_in", zero_in, fl);
      chk("out_valid", out_valid, (c >= out_lo) && (c <= out_hi));
      chk("busy", busy, (c >= 1) && (c <= out_hi));
      chk("frame_done", frame_done,
          (c >= out_lo + N) && (c <= out_hi + 1) && ((c - out_lo) % N == 0));
      chk("sample_cnt", sample_cnt, acc % N);
      if (en) chk("bf_sel", bf_sel, exp_bf(e));
      pop_check();
      if (v) begin
        exp_q.push_back(bitrev(acc % N));
        acc++;
      end
      if (en) e++;
      @(posedge clk);
      #1;
    end
    chk("sb_drained", exp_q.size(), 0);
  endtask

  // in_valid stays high through the flush of frame 1; the held sample must
  // wait for IDLE and then start frame 2.
  task automatic held_flush();
    int   acc;
    logic v, done;
    acc  = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      v = (c < 32) ? 1'b1 : ((c == 32) ? 1'b0 : (acc < 64));
      in_valid = v;
      @(negedge clk);
      if (c >= 32 && c <= 67) chk("held_in_ready", in_ready, c >= 67);
      chk("held_sample_cnt", sample_cnt, acc % N);
      pop_check();
      if (v && (c < 32 || c >= 67)) begin
        exp_q.push_back(bitrev(acc % N));
        acc++;
      end
      if (c > 67 && acc == 64 && !busy) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("held_finished", done, 1);
    chk("held_sb_drained", exp_q.size(), 0);
  endtask

  // One frame with random in-frame stalls.
  task automatic random_frame();
    int   acc;
    logic v, done;
    acc  = 0;
    done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      v = (acc == 0) || ((acc < N) && ($urandom_range(0, 3) != 0));
      in_valid = v;
      @(negedge clk);
      if (v) chk("rnd_in_ready", in_ready, 1);
      chk("rnd_sample_cnt", sample_cnt, acc % N);
      pop_check();
      if (v) begin
        exp_q.push_back(bitrev(acc));
        acc++;
      end
      if (acc == N && !busy && c > 0) done = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("rnd_finished", done, 1);
    chk("rnd_sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame(-1, -1, 1, -1);
    run_frame(-1, -1, 2, -1);
    run_frame(10, 14, 1, -1);
    run_frame(-1, -1, 1, 50);
    repeat (5) @(posedge clk);
    #1;
    check_idle_outs("held_rst");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    run_frame(-1, -1, 1, -1);
    held_flush();
    repeat (2) random_frame();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
